// File: rtl/matmul_tile_scheduler.sv
// APB-programmed tile sequencer: walks NUM_TILES tiles through a matmul engine, stepping
// the A/B/C BRAM base addresses by STRIDE per tile and raising DONE/irq at the end.
module matmul_tile_scheduler #(
  parameter int unsigned REG_ADDRWIDTH = 8,
  parameter int unsigned REG_DATAWIDTH = 32,
  parameter int unsigned AWIDTH        = 10
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [REG_ADDRWIDTH-1:0] PADDR,
  input  logic                     PWRITE,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic [REG_DATAWIDTH-1:0] PWDATA,
  output logic [REG_DATAWIDTH-1:0] PRDATA,
  output logic                     PREADY,
  output logic                     start_mat_mul,
  input  logic                     done_mat_mul,
  output logic [AWIDTH-1:0]        addr_a,
  output logic [AWIDTH-1:0]        addr_b,
  output logic [AWIDTH-1:0]        addr_c,
  output logic                     accumulate,
  output logic                     busy,
  output logic                     irq
);

  localparam logic [REG_ADDRWIDTH-1:0] AddrCtrl   = 'h00;
  localparam logic [REG_ADDRWIDTH-1:0] AddrStatus = 'h04;
  localparam logic [REG_ADDRWIDTH-1:0] AddrBaseA  = 'h08;
  localparam logic [REG_ADDRWIDTH-1:0] AddrBaseB  = 'h0C;
  localparam logic [REG_ADDRWIDTH-1:0] AddrBaseC  = 'h10;
  localparam logic [REG_ADDRWIDTH-1:0] AddrNum    = 'h14;
  localparam logic [REG_ADDRWIDTH-1:0] AddrStride = 'h18;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StFinish} state_e;

  state_e              state_q, state_d;
  logic                acc_en_q, acc_en_d;
  logic                irq_en_q, irq_en_d;
  logic                done_q, done_d;
  logic [AWIDTH-1:0]   base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  logic [AWIDTH-1:0]   stride_q, stride_d;
  logic [7:0]          num_tiles_q, num_tiles_d;
  logic [7:0]          tile_cnt_q, tile_cnt_d;
  logic [AWIDTH-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
  logic [REG_DATAWIDTH-1:0] rdata, prdata_d;

  logic wr_en, rd_setup, start_req;
  logic unused_wdata;

  assign wr_en        = PSEL && PENABLE && PWRITE;
  assign rd_setup     = PSEL && !PENABLE && !PWRITE;
  assign PREADY       = PSEL && PENABLE;
  assign busy         = (state_q != StIdle);
  assign start_req    = wr_en && !busy && (PADDR == AddrCtrl) && PWDATA[0];
  assign unused_wdata = ^PWDATA[REG_DATAWIDTH-1:AWIDTH];

  assign start_mat_mul = (state_q == StLaunch);
  // Derived from state so it stays flat from launch through the done cycle.
  assign accumulate    = ((state_q == StLaunch) || (state_q == StWait)) && acc_en_q &&
                         (tile_cnt_q != 8'd0);
  assign addr_a        = addr_a_q;
  assign addr_b        = addr_b_q;
  assign addr_c        = addr_c_q;
  assign irq           = done_q && irq_en_q;

  always_comb begin
    rdata = '0;
    case (PADDR)
      AddrCtrl:   rdata[2:1] = {irq_en_q, acc_en_q};
      AddrStatus: begin
        rdata[0]    = busy;
        rdata[1]    = done_q;
        rdata[15:8] = tile_cnt_q;
      end
      AddrBaseA:  rdata[AWIDTH-1:0] = base_a_q;
      AddrBaseB:  rdata[AWIDTH-1:0] = base_b_q;
      AddrBaseC:  rdata[AWIDTH-1:0] = base_c_q;
      AddrNum:    rdata[7:0] = num_tiles_q;
      AddrStride: rdata[AWIDTH-1:0] = stride_q;
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_en_d    = acc_en_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    base_a_d    = base_a_q;
    base_b_d    = base_b_q;
    base_c_d    = base_c_q;
    stride_d    = stride_q;
    num_tiles_d = num_tiles_q;
    tile_cnt_d  = tile_cnt_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    addr_c_d    = addr_c_q;
    prdata_d    = rd_setup ? rdata : PRDATA;

    if (wr_en && !busy) begin
      case (PADDR)
        AddrCtrl: begin
          acc_en_d = PWDATA[1];
          irq_en_d = PWDATA[2];
        end
        AddrBaseA:  base_a_d    = PWDATA[AWIDTH-1:0];
        AddrBaseB:  base_b_d    = PWDATA[AWIDTH-1:0];
        AddrBaseC:  base_c_d    = PWDATA[AWIDTH-1:0];
        AddrNum:    num_tiles_d = PWDATA[7:0];
        AddrStride: stride_d    = PWDATA[AWIDTH-1:0];
        default:    ;
      endcase
    end
    if (wr_en && (PADDR == AddrStatus) && PWDATA[1]) begin
      done_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          tile_cnt_d = 8'd0;
          addr_a_d   = base_a_q;
          addr_b_d   = base_b_q;
          addr_c_d   = base_c_q;
          done_d     = 1'b0;
          state_d    = (num_tiles_q == 8'd0) ? StFinish : StLaunch;
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (done_mat_mul) begin
          tile_cnt_d = tile_cnt_q + 8'd1;
          if (tile_cnt_q + 8'd1 == num_tiles_q) begin
            state_d = StFinish;
          end else begin
            addr_a_d = addr_a_q + stride_q;
            addr_b_d = addr_b_q + stride_q;
            if (!acc_en_q) begin
              addr_c_d = addr_c_q + stride_q;
            end
            state_d = StLaunch;
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      acc_en_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      base_c_q    <= '0;
      stride_q    <= '0;
      num_tiles_q <= '0;
      tile_cnt_q  <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_c_q    <= '0;
      PRDATA      <= '0;
    end else begin
      state_q     <= state_d;
      acc_en_q    <= acc_en_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      base_a_q    <= base_a_d;
      base_b_q    <= base_b_d;
      base_c_q    <= base_c_d;
      stride_q    <= stride_d;
      num_tiles_q <= num_tiles_d;
      tile_cnt_q  <= tile_cnt_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      addr_c_q    <= addr_c_d;
      PRDATA      <= prdata_d;
    end
  end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: directed and randomized tile sequences checked against an
// arithmetic model of the expected per-tile addresses, accumulate flags and status.
module tb_matmul_tile_scheduler;

  localparam int AW   = 10;
  localparam int MASK = (1 << AW) - 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  PADDR;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, start_mat_mul, done_mat_mul, accumulate, busy, irq;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic        eng_done = 1'b0;
  logic        spur_done = 1'b0;

  assign done_mat_mul = eng_done | spur_done;

  matmul_tile_scheduler #(
    .REG_ADDRWIDTH(8),
    .REG_DATAWIDTH(32),
    .AWIDTH(AW)
  ) dut (
    .clk(clk), .resetn(resetn), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul), .addr_a(addr_a),
    .addr_b(addr_b), .addr_c(addr_c), .accumulate(accumulate), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int eng_delay = 5;
  int eng_cnt = 0;
  int busy_cycles = 0;
  int la[$], lb[$], lc[$], lacc[$], da[$], db[$], dc[$], dacc[$];

  // Engine stand-in: records what it sees at each launch and at its own done pulse.
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (!resetn) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done = 1'b1;
          da.push_back(int'(addr_a)); db.push_back(int'(addr_b));
          dc.push_back(int'(addr_c)); dacc.push_back(int'(accumulate));
        end
      end
      if (start_mat_mul) begin
        la.push_back(int'(addr_a)); lb.push_back(int'(addr_b));
        lc.push_back(int'(addr_c)); lacc.push_back(int'(accumulate));
        eng_cnt = eng_delay;
      end
      if (busy) busy_cycles++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    step();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    #1 chk("pready_setup", {31'd0, PREADY}, 32'd0);
    step();
    PENABLE = 1'b1;
    #1 chk("pready_access", {31'd0, PREADY}, 32'd1);
    step();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    step();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    step();
    PENABLE = 1'b1;
    d = PRDATA;
    step();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic start_seq(input int ba, input int bb, input int bc, input int st,
                           input int n, input int ctrl);
    apb_write(8'h08, 32'(ba));
    apb_write(8'h0C, 32'(bb));
    apb_write(8'h10, 32'(bc));
    apb_write(8'h18, 32'(st));
    apb_write(8'h14, 32'(n));
    la.delete(); lb.delete(); lc.delete(); lacc.delete();
    da.delete(); db.delete(); dc.delete(); dacc.delete();
    busy_cycles = 0;
    apb_write(8'h00, 32'(ctrl));
  endtask

  // Expected tile i: A/B step by stride; C steps unless accumulating; accumulate on tiles > 0.
  task automatic finish_seq(input string tag, input int ba, input int bb, input int bc,
                            input int st, input int n, input int ctrl);
    int k = 0;
    bit acc;
    int ea, eb, ec, eacc;
    acc = ctrl[1];
    while (busy && k < 5000) begin
      step();
      k++;
    end
    chk({tag, "_timeout"}, 32'(k < 5000), 32'd1);
    chk({tag, "_launches"}, 32'(la.size()), 32'(n));
    chk({tag, "_dones"}, 32'(da.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      ea   = (ba + i * st) & MASK;
      eb   = (bb + i * st) & MASK;
      ec   = acc ? (bc & MASK) : ((bc + i * st) & MASK);
      eacc = (acc && i > 0) ? 1 : 0;
      if (i < la.size()) begin
        chk({tag, "_addr_a"}, 32'(la[i]), 32'(ea));
        chk({tag, "_addr_b"}, 32'(lb[i]), 32'(eb));
        chk({tag, "_addr_c"}, 32'(lc[i]), 32'(ec));
        chk({tag, "_acc"}, 32'(lacc[i]), 32'(eacc));
      end
      if (i < da.size()) begin
        chk({tag, "_hold_a"}, 32'(da[i]), 32'(ea));
        chk({tag, "_hold_b"}, 32'(db[i]), 32'(eb));
        chk({tag, "_hold_c"}, 32'(dc[i]), 32'(ec));
        chk({tag, "_hold_acc"}, 32'(dacc[i]), 32'(eacc));
      end
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(n * (1 + eng_delay) + 1));
    chk({tag, "_irq"}, {31'd0, irq}, 32'(ctrl[2]));
    read_chk({tag, "_status"}, 8'h04, 32'((n << 8) | 2));
    read_chk({tag, "_ctrl"}, 8'h00, 32'(ctrl & 6));
  endtask

  initial begin
    int ba, bb, bc, st, n, ctrl, k;
    logic [31:0] d;
    resetn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start_mat_mul}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_addr_a", 32'(addr_a), 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    resetn = 1'b1;
    step();
    read_chk("rst_status", 8'h04, 32'd0);
    read_chk("unmapped", 8'h1C, 32'd0);

    // Plain three-tile run, then the accumulate variant.
    eng_delay = 5;
    start_seq(32'h10, 32'h20, 32'h30, 4, 3, 1);
    finish_seq("basic", 32'h10, 32'h20, 32'h30, 4, 3, 1);
    start_seq(32'h10, 32'h20, 32'h30, 4, 3, 3);
    finish_seq("accum", 32'h10, 32'h20, 32'h30, 4, 3, 3);

    // Zero tiles: straight to done, then clear DONE through STATUS.
    start_seq(32'h10, 32'h20, 32'h30, 4, 0, 5);
    finish_seq("zero", 32'h10, 32'h20, 32'h30, 4, 0, 5);
    apb_write(8'h04, 32'h2);
    chk("zero_irq_clr", {31'd0, irq}, 32'd0);
    read_chk("zero_status_clr", 8'h04, 32'd0);

    // Address wrap.
    start_seq(32'h3FC, 32'h3FD, 32'h3FE, 8, 2, 1);
    finish_seq("wrap", 32'h3FC, 32'h3FD, 32'h3FE, 8, 2, 1);

    // Writes while busy are dropped; one sequence only.
    eng_delay = 20;
    start_seq(32'h100, 32'h200, 32'h300, 32'h10, 2, 1);
    repeat (3) step();
    apb_write(8'h08, 32'h55);
    apb_write(8'h00, 32'h1);
    finish_seq("busywr", 32'h100, 32'h200, 32'h300, 32'h10, 2, 1);
    read_chk("busywr_base_a", 8'h08, 32'h100);

    // Spurious done while idle.
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    chk("spur_busy", {31'd0, busy}, 32'd0);
    step();
    chk("spur_start", {31'd0, start_mat_mul}, 32'd0);
    chk("spur_addr_a", 32'(addr_a), 32'h110);
    read_chk("spur_status", 8'h04, 32'h202);

    // Randomized runs against the model.
    for (int r = 0; r < 6; r++) begin
      ba = int'($urandom_range(0, MASK));
      bb = int'($urandom_range(0, MASK));
      bc = int'($urandom_range(0, MASK));
      st = int'($urandom_range(0, MASK));
      n  = int'($urandom_range(1, 5));
      ctrl = int'($urandom_range(0, 3)) * 2 + 1;
      eng_delay = int'($urandom_range(1, 6));
      start_seq(ba, bb, bc, st, n, ctrl);
      finish_seq("rand", ba, bb, bc, st, n, ctrl);
    end

    // Abort mid-sequence with reset during tile 1.
    eng_delay = 10;
    start_seq(32'h40, 32'h80, 32'hC0, 2, 3, 7);
    k = 0;
    while (la.size() < 2 && k < 500) begin
      step();
      k++;
    end
    chk("abort_reach_tile1", 32'(la.size()), 32'd2);
    apb_read(8'h08, d);
    chk("abort_pre_read", d, 32'h40);
    resetn = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_start", {31'd0, start_mat_mul}, 32'd0);
    chk("abort_acc", {31'd0, accumulate}, 32'd0);
    chk("abort_addr_a", 32'(addr_a), 32'd0);
    chk("abort_addr_c", 32'(addr_c), 32'd0);
    chk("abort_irq", {31'd0, irq}, 32'd0);
    chk("abort_prdata", PRDATA, 32'd0);
    step();
    resetn = 1'b1;
    repeat (20) step();
    chk("abort_no_relaunch", 32'(la.size()), 32'd2);
    read_chk("abort_base_a", 8'h08, 32'd0);
    read_chk("abort_num", 8'h14, 32'd0);
    read_chk("abort_stride", 8'h18, 32'd0);
    read_chk("abort_ctrl", 8'h00, 32'd0);
    read_chk("abort_status", 8'h04, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_tile_scheduler.md
MATMUL_TILE_SCHEDULER -- requirements
Module: matmul_tile_scheduler

Interface
REQ-001 SHALL have parameter REG_ADDRWIDTH, 8, APB address width.
REQ-002 SHALL have parameter REG_DATAWIDTH, 32, APB data width.
REQ-003 SHALL have parameter AWIDTH, 10, BRAM address width.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have APB slave ports PADDR input REG_ADDRWIDTH, PWRITE input 1, PSEL input 1, PENABLE input 1, PWDATA input REG_DATAWIDTH, PRDATA output REG_DATAWIDTH, PREADY output 1.
REQ-007 SHALL have port start_mat_mul  output  1  one-cycle tile launch pulse to engine.
REQ-008 SHALL have port done_mat_mul  input  1  one-cycle tile completion pulse from engine.
REQ-009 SHALL have ports addr_a, addr_b, addr_c  output  AWIDTH each  tile base addresses for BRAMs A/B/C.
REQ-010 SHALL have port accumulate  output  1  engine adds into existing C contents.
REQ-011 SHALL have ports busy, irq  output  1 each  sequence active; completion interrupt.

Function
REQ-012 SHALL decode registers: 0x00 CTRL (bit0 START write-1 self-clearing, bit1 ACC_EN, bit2 IRQ_EN); 0x04 STATUS (bit0 BUSY ro, bit1 DONE sticky write-1-to-clear, bits15:8 tile_cnt ro); 0x08 BASE_A; 0x0C BASE_B; 0x10 BASE_C; 0x14 NUM_TILES (bits7:0); 0x18 STRIDE (AWIDTH bits).
REQ-013 SHALL assert PREADY only when PSEL&&PENABLE (zero wait states), 0 otherwise.
REQ-014 SHALL commit writes on the clock edge where PSEL&&PENABLE&&PWRITE; unmapped addresses ignored.
REQ-015 SHALL load PRDATA on the edge where PSEL&&!PENABLE&&!PWRITE with selected register (unmapped = 0) and hold it until the next read setup.
REQ-016 SHALL ignore writes to CTRL, BASE_*, NUM_TILES, STRIDE while busy; STATUS DONE clear always accepted.
REQ-017 SHALL implement FSM IDLE, LAUNCH, WAIT, FINISH.
REQ-018 IDLE: on accepted START write go to LAUNCH next cycle, load tile_cnt=0, addr_a/b/c=BASE_A/B/C, clear DONE; if NUM_TILES=0 go to FINISH instead, no start pulse.
REQ-019 LAUNCH: start_mat_mul=1 for exactly this one cycle; accumulate = ACC_EN && tile_cnt!=0; then WAIT.
REQ-020 WAIT: on done_mat_mul, tile_cnt+1; if tile_cnt+1==NUM_TILES go FINISH, else addr_a+=STRIDE, addr_b+=STRIDE, addr_c+=STRIDE unless ACC_EN (addr_c held), go LAUNCH.
REQ-021 SHALL keep addresses modulo 2^AWIDTH (wrap, no error).
REQ-022 FINISH: set DONE, go IDLE next cycle; busy=1 in LAUNCH, WAIT, FINISH, 0 in IDLE.
REQ-023 SHALL ignore done_mat_mul in IDLE, LAUNCH, FINISH.
REQ-024 irq SHALL equal DONE && IRQ_EN, combinational from registers.
REQ-025 START write with DONE-clear in same cycle: start wins, DONE=0.
REQ-026 accumulate and addr_* SHALL hold stable from LAUNCH through the done_mat_mul cycle.

Reset
REQ-027 resetn low SHALL immediately force IDLE, all registers 0, PRDATA=0, start_mat_mul=0, accumulate=0, busy=0, irq=0, addr_*=0, regardless of state (mid-sequence abort).
REQ-028 First edge after resetn deasserts SHALL behave as IDLE with cleared registers.

Verification
REQ-029 BASE_A=0x10, BASE_B=0x20, BASE_C=0x30, STRIDE=4, NUM_TILES=3, CTRL=0x1; engine done 5 cycles after each start -> 3 start pulses, addr_a 0x10/0x14/0x18, addr_c 0x30/0x34/0x38, accumulate=0, then STATUS reads 0x0302.
REQ-030 Same with CTRL=0x3 -> addr_c 0x30 all tiles, accumulate 0/1/1.
REQ-031 NUM_TILES=0, CTRL=0x5 -> no start pulse, busy high 1 cycle, DONE=1, irq=1; write STATUS=0x2 -> irq=0.
REQ-032 BASE_A=0x3FC, STRIDE=8, NUM_TILES=2 -> addr_a 0x3FC then 0x004.
REQ-033 During WAIT: write BASE_A=0x55 and CTRL=0x1 -> both ignored, BASE_A readback unchanged, single sequence; spurious done_mat_mul in IDLE -> no state change.
REQ-034 resetn low in WAIT of tile 1 -> busy=0, start_mat_mul=0, registers read 0 after release.
